seq_compare: RTL and testbench
==============================

SEQ_COMPARE -- requirements
Module: seq_compare

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width in bits.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits compared per clock; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
REQ-003 iClk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 iRst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 iStart  input  1  SHALL request a new comparison.
REQ-006 iSigned  input  1  SHALL select two's-complement (1) or unsigned (0) comparison; sampled with iStart.
REQ-007 iData_a  input  WIDTH  SHALL be operand A; sampled with iStart.
REQ-008 iData_b  input  WIDTH  SHALL be operand B; sampled with iStart.
REQ-009 oBusy  output  1  SHALL be high while a comparison is in progress.
REQ-010 oDone  output  1  SHALL be a one-cycle pulse marking a valid new result.
REQ-011 oData  output  3  SHALL be the one-hot result: 100 = A>B, 010 = A<B, 001 = A==B.
REQ-012 oCount  output  clog2(NCHUNK+1)  SHALL give the number of chunks examined for the last result.

Function
REQ-013 The block SHALL have two states: IDLE and RUN.
REQ-014 In IDLE, a rising edge with iStart=1 SHALL perform the following:
- latch iData_a, iData_b and iSigned;
- set chunk index to NCHUNK-1 (MSB chunk);
- clear the internal chunk counter;
- enter RUN with oBusy=1.
REQ-015 iStart while in RUN SHALL be ignored; latched operands SHALL NOT change.
REQ-016 In RUN, each edge SHALL compare one CHUNK-bit slice at the current index, unsigned, MSB chunk first.
REQ-017 When signed mode is latched, the top bit of the MSB chunk of both operands SHALL be inverted before comparing; all other chunks compare unsigned.
REQ-018 If the slices differ, or the index is 0, the block SHALL complete on that edge:
- load oData with the result (100/010; 001 only when index 0 and equal);
- load oCount with the chunks examined;
- set oDone=1 for exactly one cycle;
- clear oBusy;
- return to IDLE.
REQ-019 Otherwise the block SHALL decrement the index and remain in RUN.
REQ-020 Latency SHALL be data dependent:
- oDone is high in the cycle after edge E+k, where E is the start edge and k (1..NCHUNK) is the position from the MSB of the first differing chunk;
- k = NCHUNK when the operands are equal.
REQ-021 oData and oCount SHALL hold their last values until the next completion; they SHALL NOT change during RUN.
REQ-022 iStart=1 in the cycle oDone is high SHALL be accepted (block is IDLE), giving back-to-back operation with no dead cycle.
REQ-023 With CHUNK = WIDTH (NCHUNK=1), every comparison SHALL complete one edge after start.

Reset
REQ-024 iRst=1 SHALL immediately, without a clock edge, force:
- state IDLE;
- oBusy=0 and oDone=0;
- oData=000 (no result);
- oCount=0;
- cleared internal registers.
REQ-025 Reset asserted during RUN SHALL abort the comparison with no oDone pulse.
REQ-026 After reset deasserts, the first iStart SHALL be accepted normally.

Verification (WIDTH=32, CHUNK=4)
REQ-027 Scenario: A=0x12345678, B=0x12345678, unsigned -> oDone in the cycle after the 8th edge following start, oData=001, oCount=8.
REQ-028 Scenario: A=0x90000000, B=0x80000000, unsigned -> early exit, oDone after edge 1, oData=100, oCount=1.
REQ-029 Scenario: A=0xFFFFFFFF, B=0x00000001:
- unsigned -> oData=100, oCount=1;
- signed -> oData=010, oCount=1.
REQ-030 Scenario: A=0x0000A000, B=0x0000B000 -> oData=010, oCount=5; iStart pulsed mid-RUN with other data -> ignored, result unchanged.
REQ-031 Scenario: iRst pulsed at edge 3 of an equal-operand run -> oBusy, oDone, oData and oCount all 0 immediately; no oDone ever; next start completes correctly.
REQ-032 Scenario: iStart held high across oDone with a new operand pair -> second comparison starts in the oDone cycle and returns the correct result with no gap.

Source files
------------

// File: rtl/seq_compare.sv
// seq_compare: chunk-serial magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first, and
// stops at the first chunk that differs or after the LSB chunk. Signed mode
// flips the sign bit of the MSB chunk so that an unsigned chunk compare gives
// the two's-complement ordering.
module seq_compare #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic                                 iStart,
    input  logic                                 iSigned,
    input  logic [WIDTH-1:0]                     iData_a,
    input  logic [WIDTH-1:0]                     iData_b,
    output logic                                 oBusy,
    output logic                                 oDone,
    output logic [2:0]                           oData,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]     oCount
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(NCHUNK + 1);

    localparam logic [IW-1:0] IDX_MSB = IW'(NCHUNK - 1);

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched operands and mode
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             signed_q;

    // Current chunk index (NCHUNK-1 = MSB chunk) and chunks examined so far
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    // Slices at the current index and their compare keys
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] key_a;
    logic [CHUNK-1:0] key_b;
    logic             a_gt;
    logic             a_lt;
    logic             at_msb;
    logic             at_lsb;

    // FSM decode strobes
    logic             accept;
    logic             finish;

    // Select the operand chunks addressed by the current index
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                slice_a = op_a[i*CHUNK +: CHUNK];
                slice_b = op_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // Form compare keys: sign bit of the MSB chunk is flipped in signed mode
    always_comb begin
        at_msb = (idx == IDX_MSB);
        at_lsb = (idx == '0);
        key_a  = slice_a;
        key_b  = slice_b;
        if (signed_q && at_msb) begin
            key_a[CHUNK-1] = ~slice_a[CHUNK-1];
            key_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
        a_gt = (key_a > key_b);
        a_lt = (key_a < key_b);
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (a_gt || a_lt || at_lsb) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, chunk walk and result registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            op_a     <= '0;
            op_b     <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            oDone    <= 1'b0;
            oData    <= '0;
            oCount   <= '0;
        end else begin
            oDone <= 1'b0;
            if (accept) begin
                op_a     <= iData_a;
                op_b     <= iData_b;
                signed_q <= iSigned;
                idx      <= IDX_MSB;
                cnt      <= '0;
            end else if (state == RUN) begin
                if (finish) begin
                    if (a_gt) begin
                        oData <= RES_GT;
                    end else if (a_lt) begin
                        oData <= RES_LT;
                    end else begin
                        oData <= RES_EQ;
                    end
                    oCount <= cnt + CW'(1);
                    oDone  <= 1'b1;
                end else begin
                    idx <= idx - IW'(1);
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign oBusy = (state == RUN);

endmodule

// File: tb/tb_seq_compare.sv
// tb_seq_compare: directed scenarios plus randomized comparisons checked
// against a behavioural model (native signed/unsigned compare, first
// differing chunk found from the XOR of the operands).
module tb_seq_compare;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic              iClk;
    logic              iRst;
    logic              iStart;
    logic              iSigned;
    logic [WIDTH-1:0]  iData_a;
    logic [WIDTH-1:0]  iData_b;
    logic              oBusy;
    logic              oDone;
    logic [2:0]        oData;
    logic [CW-1:0]     oCount;

    int checks = 0;
    int errors = 0;

    seq_compare #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData),
        .oCount  (oCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected one-hot result from plain arithmetic ordering
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b010;
        end else begin
            if (a > b) return 3'b100;
            if (a < b) return 3'b010;
        end
        return 3'b001;
    endfunction

    // Position (1 = MSB chunk) of the first differing chunk, NCHUNK if equal
    function automatic int model_k(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] chunk;
        diff = a ^ b;
        for (int p = 1; p <= NCHUNK; p++) begin
            chunk = (diff >> (WIDTH - p * CHUNK)) & ((WIDTH'(1) << CHUNK) - WIDTH'(1));
            if (chunk != '0) return p;
        end
        return NCHUNK;
    endfunction

    // Start a comparison at the current negedge and follow it to oDone.
    // Returns at the negedge of the oDone cycle so a following call starts
    // back-to-back. With noise=1, iStart is pulsed with other data mid-run.
    task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input bit noise);
        logic [2:0]    exp_res;
        logic [2:0]    prev_data;
        logic [CW-1:0] prev_count;
        int            exp_k;
        int            n;
        bit            held;
        exp_res    = model_res(a, b, s);
        exp_k      = model_k(a, b);
        prev_data  = oData;
        prev_count = oCount;
        iStart     = 1'b1;
        iData_a    = a;
        iData_b    = b;
        iSigned    = s;
        @(negedge iClk);
        iStart = 1'b0;
        check("busy_after_start", 32'(oBusy), 32'd1);
        check("done_low_after_start", 32'(oDone), 32'd0);
        n    = 0;
        held = 1'b1;
        while (!oDone && n < NCHUNK + 4) begin
            if (noise) begin
                iStart  = 1'b1;
                iData_a = $urandom;
                iData_b = $urandom;
                iSigned = 1'($urandom_range(0, 1));
            end
            @(negedge iClk);
            n++;
            if (!oDone && (oData !== prev_data || oCount !== prev_count)) held = 1'b0;
        end
        iStart = 1'b0;
        check("result_held_in_run", 32'(held), 32'd1);
        check("latency", 32'(n), 32'(exp_k));
        check("result", 32'(oData), 32'(exp_res));
        check("count", 32'(oCount), 32'(exp_k));
        check("busy_at_done", 32'(oBusy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               seen_done;
        int               mode;
        int               pos;

        iRst    = 1'b1;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iData_a = '0;
        iData_b = '0;

        @(negedge iClk);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_count", 32'(oCount), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);

        // Directed scenarios
        do_cmp(32'h12345678, 32'h12345678, 1'b0, 1'b0);
        do_cmp(32'h90000000, 32'h80000000, 1'b0, 1'b0);
        @(negedge iClk);
        do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        @(negedge iClk);
        do_cmp(32'h0000A000, 32'h0000B000, 1'b0, 1'b1);
        // Back-to-back: second start issued in the oDone cycle of the first
        do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
        do_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);

        // Reset in the middle of an equal-operand run
        iStart  = 1'b1;
        iData_a = 32'hCAFEF00D;
        iData_b = 32'hCAFEF00D;
        iSigned = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (2) @(negedge iClk);
        @(posedge iClk);
        #2 iRst = 1'b1;
        #1;
        check("abort_busy", 32'(oBusy), 32'd0);
        check("abort_done", 32'(oDone), 32'd0);
        check("abort_data", 32'(oData), 32'd0);
        check("abort_count", 32'(oCount), 32'd0);
        @(negedge iClk);
        iRst      = 1'b0;
        seen_done = 1'b0;
        repeat (NCHUNK + 2) begin
            @(negedge iClk);
            if (oDone) seen_done = 1'b1;
        end
        check("no_done_after_abort", 32'(seen_done), 32'd0);
        check("idle_after_abort", 32'(oBusy), 32'd0);
        do_cmp(32'h0000A000, 32'h0000B000, 1'b0, 1'b0);

        // Randomized comparisons with varied depth, gaps and mid-run noise
        for (int t = 0; t < 60; t++) begin
            a    = $urandom;
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                b = $urandom;
            end else if (mode == 1) begin
                b = a;
            end else begin
                pos = $urandom_range(0, NCHUNK - 1);
                b   = a ^ (WIDTH'($urandom_range(1, 15)) << (pos * CHUNK));
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge iClk);
            end
            do_cmp(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        @(negedge iClk);
        check("final_done_low", 32'(oDone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
